mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/rr_arb2.sv | 22 ++
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding and port identifiers for the memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    // A transaction reads memory unless it is a data-port access with a nonzero byte mask.
    function automatic logic is_load(input logic owner, input logic [3:0] wmask);
        return (owner == PORT_I) || (wmask == 4'b0000);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way priority pick between instruction and data ports
module rr_arb2
    import mem_arb_pkg::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant
);

    // A lone requester always wins; on contention either alternate or favour data.
    always_comb begin
        grant = PORT_I;
        if (req[PORT_D] && req[PORT_I]) begin
            grant = (ROUND_ROBIN != 0) ? ~last : PORT_D;
        end else if (req[PORT_D]) begin
            grant = PORT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates instruction and data ports onto one registered memory interface
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_done,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wmask,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic [31:0] mem_addr,
    output logic        mem_rstrb,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    arb_state_t  r_state;
    arb_state_t  w_next_state;
    logic        r_owner;
    logic        r_last;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_wmask;
    logic        r_mem_rstrb;
    logic        r_i_done;
    logic        r_d_done;

    logic [1:0]  w_req;
    logic        w_grant;
    logic        w_accept;
    logic [3:0]  w_grant_wmask;

    assign w_req         = {d_req, i_req};
    assign w_accept      = (r_state == ST_IDLE) && (|w_req);
    assign w_grant_wmask = (w_grant == PORT_D) ? d_wmask : 4'b0000;

    rr_arb2 #(
        .ROUND_ROBIN (ROUND_ROBIN)
    ) u_rr_arb2 (
        .req   (w_req),
        .last  (r_last),
        .grant (w_grant)
    );

    // State register; reset drops any in-flight transaction back to idle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Fixed three-step sequence; requests are only looked at while idle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (|w_req) w_next_state = ST_ACCESS;
            ST_ACCESS: w_next_state = ST_RESP;
            ST_RESP:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Capture the winner's request on acceptance; strobe/mask live for the ACCESS cycle only,
    // and the owner's done is raised for the RESP cycle while memory data is valid.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_owner     <= PORT_I;
            r_last      <= PORT_D;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_mem_wmask <= 4'b0000;
            r_mem_rstrb <= 1'b0;
            r_i_done    <= 1'b0;
            r_d_done    <= 1'b0;
        end else begin
            r_mem_wmask <= 4'b0000;
            r_mem_rstrb <= 1'b0;
            r_i_done    <= 1'b0;
            r_d_done    <= 1'b0;
            if (w_accept) begin
                r_owner     <= w_grant;
                r_last      <= w_grant;
                r_mem_addr  <= (w_grant == PORT_D) ? d_addr : i_addr;
                r_mem_wdata <= (w_grant == PORT_D) ? d_wdata : 32'h0;
                r_mem_wmask <= w_grant_wmask;
                r_mem_rstrb <= is_load(w_grant, w_grant_wmask);
            end
            if (r_state == ST_ACCESS) begin
                r_i_done <= (r_owner == PORT_I);
                r_d_done <= (r_owner == PORT_D);
            end
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wmask = r_mem_wmask;
    assign mem_rstrb = r_mem_rstrb;
    assign i_done    = r_i_done;
    assign d_done    = r_d_done;
    assign i_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk;
    logic        resetn;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wmask;

    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        i_done, d_done, mem_rstrb, busy;
    logic [3:0]  mem_wmask;

    logic [31:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1;
    logic        i_done1, d_done1, mem_rstrb1, busy1;
    logic [3:0]  mem_wmask1;
    logic [31:0] mem_rdata1;

    logic [31:0] mem [0:63];
    logic        mem_init;

    int checks;
    int errors;

    mem_arbiter #(.ROUND_ROBIN(1)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_done    (i_done),
        .d_req     (d_req),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wmask   (d_wmask),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .mem_addr  (mem_addr),
        .mem_rstrb (mem_rstrb),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    mem_arbiter #(.ROUND_ROBIN(0)) dut_fixed (
        .clk       (clk),
        .resetn    (resetn),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata1),
        .i_done    (i_done1),
        .d_req     (d_req),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wmask   (d_wmask),
        .d_rdata   (d_rdata1),
        .d_done    (d_done1),
        .mem_addr  (mem_addr1),
        .mem_rstrb (mem_rstrb1),
        .mem_wdata (mem_wdata1),
        .mem_wmask (mem_wmask1),
        .mem_rdata (mem_rdata1),
        .busy      (busy1)
    );

    assign mem_rdata1 = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory: read data valid the cycle after a strobe edge, byte-masked writes.
    always @(posedge clk) begin
        if (mem_init) begin
            mem[4]    <= 32'h0000_0093;
            mem[8]    <= 32'h1122_3344;
            mem_rdata <= 32'h0;
        end else begin
            if (mem_rstrb) mem_rdata <= mem[mem_addr[7:2]];
            if (mem_wmask[0]) mem[mem_addr[7:2]][7:0]   <= mem_wdata[7:0];
            if (mem_wmask[1]) mem[mem_addr[7:2]][15:8]  <= mem_wdata[15:8];
            if (mem_wmask[2]) mem[mem_addr[7:2]][23:16] <= mem_wdata[23:16];
            if (mem_wmask[3]) mem[mem_addr[7:2]][31:24] <= mem_wdata[31:24];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req   = 1'b0;
        i_addr  = 32'h0;
        d_req   = 1'b0;
        d_addr  = 32'h0;
        d_wdata = 32'h0;
        d_wmask = 4'b0000;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        mem_init = 1'b1;
        idle_inputs();
        resetn = 1'b0;
        step();
        step();
        mem_init = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        checks++;
        if (mem_rstrb !== 1'b0 || mem_wmask !== 4'b0000) begin
            errors++; $display("FAIL reset_strobe got rstrb=%0b wmask=%b exp 0/0000", mem_rstrb, mem_wmask);
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++; $display("FAIL reset_addr got addr=%h wdata=%h exp 0/0", mem_addr, mem_wdata);
        end
        checks++;
        if (i_done !== 1'b0 || d_done !== 1'b0) begin
            errors++; $display("FAIL reset_done got i=%0b d=%0b exp 0/0", i_done, d_done);
        end
        resetn = 1'b1;
    endtask

    task automatic test_single_fetch();
        i_req  = 1'b1;
        i_addr = 32'h10;
        step();
        checks++;
        if (mem_rstrb !== 1'b1 || mem_addr !== 32'h10 || busy !== 1'b1 || i_done !== 1'b0) begin
            errors++; $display("FAIL fetch_access got rstrb=%0b addr=%h busy=%0b idone=%0b exp 1/10/1/0",
                               mem_rstrb, mem_addr, busy, i_done);
        end
        step();
        checks++;
        if (i_done !== 1'b1 || i_rdata !== 32'h0000_0093 || d_done !== 1'b0 || mem_rstrb !== 1'b0) begin
            errors++; $display("FAIL fetch_resp got idone=%0b rdata=%h ddone=%0b rstrb=%0b exp 1/00000093/0/0",
                               i_done, i_rdata, d_done, mem_rstrb);
        end
        i_req = 1'b0;
        step();
        checks++;
        if (i_done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL fetch_idle got idone=%0b busy=%0b exp 0/0", i_done, busy);
        end
    endtask

    task automatic test_store();
        d_req   = 1'b1;
        d_addr  = 32'h20;
        d_wdata = 32'hDEAD_BEEF;
        d_wmask = 4'b0011;
        step();
        checks++;
        if (mem_wmask !== 4'b0011 || mem_rstrb !== 1'b0 || mem_addr !== 32'h20 || mem_wdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL store_access got wmask=%b rstrb=%0b addr=%h wdata=%h exp 0011/0/20/deadbeef",
                               mem_wmask, mem_rstrb, mem_addr, mem_wdata);
        end
        step();
        checks++;
        if (d_done !== 1'b1 || i_done !== 1'b0 || mem_wmask !== 4'b0000) begin
            errors++; $display("FAIL store_resp got ddone=%0b idone=%0b wmask=%b exp 1/0/0000",
                               d_done, i_done, mem_wmask);
        end
        checks++;
        if (mem[8] !== 32'h1122_BEEF) begin
            errors++; $display("FAIL store_data got %h exp 1122beef", mem[8]);
        end
        d_req   = 1'b0;
        d_wmask = 4'b0000;
        step();
    endtask

    task automatic test_single_requester();
        do_reset();
        d_req  = 1'b1;
        d_addr = 32'h20;
        step();
        step();
        checks++;
        if (d_done !== 1'b1 || i_done !== 1'b0 || d_rdata !== 32'h1122_BEEF) begin
            errors++; $display("FAIL lone_data got ddone=%0b idone=%0b rdata=%h exp 1/0/1122beef",
                               d_done, i_done, d_rdata);
        end
        d_req = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [3:0] seq;
        int n;
        logic both;
        seq  = 4'b0000;
        n    = 0;
        both = 1'b0;
        do_reset();
        i_req  = 1'b1;
        i_addr = 32'h10;
        d_req  = 1'b1;
        d_addr = 32'h20;
        for (int c = 0; c < 12; c++) begin
            step();
            if (i_done && d_done) both = 1'b1;
            if (i_done && n < 4) begin seq[n] = 1'b0; n++; end
            if (d_done && n < 4) begin seq[n] = 1'b1; n++; end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        checks++;
        if (n !== 4 || seq !== 4'b1010) begin
            errors++; $display("FAIL rr_order got n=%0d seq=%b exp 4/1010 (bit0 first, 1=data)", n, seq);
        end
        checks++;
        if (both !== 1'b0) begin errors++; $display("FAIL rr_both_done got 1 exp 0"); end
        step();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rr_drain got busy=%0b exp 0", busy); end
    endtask

    task automatic test_fixed_priority();
        int ni;
        int nd;
        ni = 0;
        nd = 0;
        do_reset();
        i_req  = 1'b1;
        i_addr = 32'h10;
        d_req  = 1'b1;
        d_addr = 32'h20;
        for (int c = 0; c < 12; c++) begin
            step();
            if (i_done1) ni++;
            if (d_done1) nd++;
        end
        i_req = 1'b0;
        d_req = 1'b0;
        checks++;
        if (nd !== 4 || ni !== 0) begin
            errors++; $display("FAIL fixed_prio got d=%0d i=%0d exp 4/0", nd, ni);
        end
        step();
        checks++;
        if (busy1 !== 1'b0 || mem_addr1 !== 32'h20) begin
            errors++; $display("FAIL fixed_addr got busy=%0b addr=%h exp 0/20", busy1, mem_addr1);
        end
    endtask

    task automatic test_reset_in_access();
        do_reset();
        i_req  = 1'b1;
        i_addr = 32'h10;
        step();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL abort_pre got busy=%0b exp 1", busy); end
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        checks++;
        if (busy !== 1'b0 || mem_rstrb !== 1'b0 || i_done !== 1'b0 || d_done !== 1'b0) begin
            errors++; $display("FAIL abort_state got busy=%0b rstrb=%0b idone=%0b ddone=%0b exp 0/0/0/0",
                               busy, mem_rstrb, i_done, d_done);
        end
        step();
        checks++;
        if (busy !== 1'b1 || mem_rstrb !== 1'b1 || i_done !== 1'b0) begin
            errors++; $display("FAIL abort_reaccept got busy=%0b rstrb=%0b idone=%0b exp 1/1/0",
                               busy, mem_rstrb, i_done);
        end
        step();
        checks++;
        if (i_done !== 1'b1 || i_rdata !== 32'h0000_0093) begin
            errors++; $display("FAIL abort_refetch got idone=%0b rdata=%h exp 1/00000093", i_done, i_rdata);
        end
        i_req = 1'b0;
        step();
    endtask

    task automatic test_owner_drop();
        d_req   = 1'b1;
        d_addr  = 32'h20;
        d_wmask = 4'b0000;
        step();
        d_req = 1'b0;
        checks++;
        if (mem_rstrb !== 1'b1 || mem_addr !== 32'h20) begin
            errors++; $display("FAIL drop_access got rstrb=%0b addr=%h exp 1/20", mem_rstrb, mem_addr);
        end
        step();
        checks++;
        if (d_done !== 1'b1 || d_rdata !== 32'h1122_BEEF) begin
            errors++; $display("FAIL drop_done got ddone=%0b rdata=%h exp 1/1122beef", d_done, d_rdata);
        end
        step();
        step();
        checks++;
        if (busy !== 1'b0 || mem_rstrb !== 1'b0 || d_done !== 1'b0) begin
            errors++; $display("FAIL drop_no_new got busy=%0b rstrb=%0b ddone=%0b exp 0/0/0",
                               busy, mem_rstrb, d_done);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        mem_init = 1'b0;
        resetn   = 1'b0;
        idle_inputs();
        test_reset();
        test_single_fetch();
        test_store();
        test_single_requester();
        test_back_to_back();
        test_fixed_priority();
        test_reset_in_access();
        test_owner_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
